// File: rtl/mem_arbiter.sv
// Two-requester (core, loader) arbiter for one shared memory; req->ready latency MEM_LAT+1, period MEM_LAT+2.
// Requesters hold req and fields until their ready pulse; grants change only in IDLE, loader lock bounded by MAX_BURST.
module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ready,
  input  logic          l_req,
  input  logic          l_lock,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic [DW-1:0] l_rdata,
  output logic          l_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] OWN_IDLE = 2'b00;
  localparam logic [1:0] OWN_CORE = 2'b01;
  localparam logic [1:0] OWN_LDR  = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic [BW-1:0] burst_cnt, burst_cnt_nxt;
  logic          last_grant, last_grant_nxt;  // 1 = loader had the last grant
  logic          we_q;
  logic          gnt_core, gnt_ldr;

  always_comb begin
    gnt_core = 1'b0;
    gnt_ldr  = 1'b0;
    if (state == IDLE) begin
      if (c_req && !l_req) begin
        gnt_core = 1'b1;
      end else if (l_req && !c_req) begin
        gnt_ldr = 1'b1;
      end else if (c_req && l_req) begin
        if (l_lock && last_grant && (burst_cnt < BW'(MAX_BURST))) begin
          gnt_ldr = 1'b1;
        end else if (last_grant) begin
          gnt_core = 1'b1;
        end else begin
          gnt_ldr = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      burst_cnt  <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    burst_cnt_nxt  = burst_cnt;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (gnt_core || gnt_ldr) state_nxt = ISSUE;
      end
      ISSUE: begin
        wait_cnt_nxt = CW'(MEM_LAT - 1);
        state_nxt    = (MEM_LAT == 1) ? DONE : WAIT;
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt - CW'(1);
        if (wait_cnt <= CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (gnt_core) last_grant_nxt = 1'b0;
    if (gnt_ldr)  last_grant_nxt = 1'b1;

    // Saturate so a stuck lock can never wrap and re-starve the core
    if (!l_lock || gnt_core) begin
      burst_cnt_nxt = '0;
    end else if (gnt_ldr && c_req && (burst_cnt != BW'(MAX_BURST))) begin
      burst_cnt_nxt = burst_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= OWN_IDLE;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (gnt_core) begin
      owner     <= OWN_CORE;
      we_q      <= c_we;
      mem_addr  <= c_addr;
      mem_wdata <= c_wdata;
    end else if (gnt_ldr) begin
      owner     <= OWN_LDR;
      we_q      <= l_we;
      mem_addr  <= l_addr;
      mem_wdata <= l_wdata;
    end else if (state == DONE) begin
      owner <= OWN_IDLE;
    end
  end

  always_comb begin
    mem_en  = (state == ISSUE);
    mem_we  = mem_en & we_q;
    c_ready = (state == DONE) && (owner == OWN_CORE);
    l_ready = (state == DONE) && (owner == OWN_LDR);
    c_rdata = c_ready ? mem_rdata : '0;
    l_rdata = l_ready ? mem_rdata : '0;
  end

endmodule
